// File: rtl/collision_pkg.sv
// Shared types and the single-pair contact rule for the collision scanner.
// An object entry is packed {left, top, right, bottom}; a contact word is
// {up, down, left, right} as seen from the sprite.
package collision_pkg;

  localparam int OBJ_COORD_W = 11;
  localparam int EXT_W       = OBJ_COORD_W + 1;

  typedef struct packed {
    logic [OBJ_COORD_W-1:0] left;
    logic [OBJ_COORD_W-1:0] top;
    logic [OBJ_COORD_W-1:0] right;
    logic [OBJ_COORD_W-1:0] bottom;
  } obj_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Scanner states, kept as plain constants so older tools can read them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SCAN    = 2'd1;
  localparam state_t ST_PUBLISH = 2'd2;

  // Evaluates one sprite box against one object box. Everything is widened
  // by one bit so sprite right/bottom edges and object edge + margin never
  // wrap. Degenerate objects (zero or negative extent) report no contact.
  function automatic dir_t box_contact(input obj_t                   obj,
                                       input logic [OBJ_COORD_W-1:0] sx,
                                       input logic [OBJ_COORD_W-1:0] sy,
                                       input int unsigned            w,
                                       input int unsigned            h,
                                       input int unsigned            margin);
    logic [EXT_W-1:0] l, t, r, b;
    logic [EXT_W-1:0] x0, y0, x1, y1;
    logic [EXT_W-1:0] m, bm, rm;
    logic             hov, vov;
    dir_t             d;
    l  = {1'b0, obj.left};
    t  = {1'b0, obj.top};
    r  = {1'b0, obj.right};
    b  = {1'b0, obj.bottom};
    x0 = {1'b0, sx};
    y0 = {1'b0, sy};
    x1 = x0 + EXT_W'(w);
    y1 = y0 + EXT_W'(h);
    m  = EXT_W'(margin);
    bm = (b >= m) ? (b - m) : '0;
    rm = (r >= m) ? (r - m) : '0;
    hov = (x0 < r) && (x1 > l);
    vov = (y0 < b) && (y1 > t);
    d = '0;
    if ((r > l) && (b > t)) begin
      d.down  = hov && (t  <= y1) && (y1 <= t + m);
      d.up    = hov && (bm <= y0) && (y0 <= b);
      d.right = vov && (l  <= x1) && (x1 <= l + m);
      d.left  = vov && (rm <= x0) && (x0 <= r);
    end
    return d;
  endfunction

endpackage

// File: rtl/box_compare.sv
// Combinational evaluator for a single (object, sprite) pair. Disabled
// table entries are masked here so the scanner only sees real contacts.
module box_compare
  import collision_pkg::*;
#(
  parameter int unsigned CHAR_WIDTH  = 22,
  parameter int unsigned CHAR_HEIGHT = 36,
  parameter int unsigned MARGIN      = 1
) (
  input  obj_t                   i_obj,
  input  logic [OBJ_COORD_W-1:0] i_sx,
  input  logic [OBJ_COORD_W-1:0] i_sy,
  input  logic                   i_enable,
  output dir_t                   o_dir
);

  // Contact flags for this pair, forced to zero for disabled entries.
  always_comb begin
    o_dir = '0;
    if (i_enable) begin
      o_dir = box_contact(i_obj, i_sx, i_sy, CHAR_WIDTH, CHAR_HEIGHT, MARGIN);
    end
  end

endmodule

// File: rtl/collision_scanner.sv
// Sequential AABB collision engine: walks every (object, sprite) pair, one
// per clock, ORs the contact flags per sprite and remembers the first
// object that touched each sprite. Results are published together with a
// one-cycle done pulse. COORD_W must match collision_pkg::OBJ_COORD_W.
module collision_scanner
  import collision_pkg::*;
#(
  parameter int unsigned OBJECT_NUM  = 18,
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned COORD_W     = OBJ_COORD_W,
  parameter int unsigned CHAR_WIDTH  = 22,
  parameter int unsigned CHAR_HEIGHT = 36,
  parameter int unsigned MARGIN      = 1,
  localparam int IDX_W = (OBJECT_NUM  > 1) ? $clog2(OBJECT_NUM)  : 1,
  localparam int SPR_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int OBJ_W = 4 * COORD_W
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_redo,
  input  logic [NUM_SPRITES*COORD_W-1:0] i_sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] i_sprite_y,
  input  logic [OBJECT_NUM*OBJ_W-1:0]    i_objects,
  input  logic [OBJECT_NUM-1:0]          i_obj_enable,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [NUM_SPRITES*4-1:0]       o_contact,
  output logic [NUM_SPRITES-1:0]         o_hit_valid,
  output logic [NUM_SPRITES*IDX_W-1:0]   o_hit_index,
  output logic [NUM_SPRITES*OBJ_W-1:0]   o_hit_object
);

  state_t                         r_state;
  logic [IDX_W-1:0]               r_obj_idx;
  logic [SPR_W-1:0]               r_spr_idx;
  logic [NUM_SPRITES*COORD_W-1:0] r_snap_x;
  logic [NUM_SPRITES*COORD_W-1:0] r_snap_y;

  logic [NUM_SPRITES*4-1:0]       r_acc_contact;
  logic [NUM_SPRITES-1:0]         r_acc_valid;
  logic [NUM_SPRITES*IDX_W-1:0]   r_acc_index;
  logic [NUM_SPRITES*OBJ_W-1:0]   r_acc_object;

  logic                           r_done;
  logic [NUM_SPRITES*4-1:0]       r_contact;
  logic [NUM_SPRITES-1:0]         r_hit_valid;
  logic [NUM_SPRITES*IDX_W-1:0]   r_hit_index;
  logic [NUM_SPRITES*OBJ_W-1:0]   r_hit_object;

  obj_t                           w_obj;
  logic [COORD_W-1:0]             w_sx;
  logic [COORD_W-1:0]             w_sy;
  logic                           w_en;
  dir_t                           w_dir;
  logic                           w_scanning;
  logic                           w_begin;
  logic                           w_last_spr;
  logic                           w_last_pair;
  logic                           w_publish;

  logic [NUM_SPRITES*4-1:0]       w_acc_contact_nxt;
  logic [NUM_SPRITES-1:0]         w_acc_valid_nxt;
  logic [NUM_SPRITES*IDX_W-1:0]   w_acc_index_nxt;
  logic [NUM_SPRITES*OBJ_W-1:0]   w_acc_object_nxt;

  // Current pair operands: the live table entry and the snapshotted sprite.
  assign w_obj = i_objects[r_obj_idx*OBJ_W +: OBJ_W];
  assign w_en  = i_obj_enable[r_obj_idx];
  assign w_sx  = r_snap_x[r_spr_idx*COORD_W +: COORD_W];
  assign w_sy  = r_snap_y[r_spr_idx*COORD_W +: COORD_W];

  box_compare #(
    .CHAR_WIDTH  (CHAR_WIDTH),
    .CHAR_HEIGHT (CHAR_HEIGHT),
    .MARGIN      (MARGIN)
  ) u_box_compare (
    .i_obj    (w_obj),
    .i_sx     (w_sx),
    .i_sy     (w_sy),
    .i_enable (w_en),
    .o_dir    (w_dir)
  );

  // A redo always restarts; start only counts when no scan is running, and
  // redo takes precedence when both arrive together.
  assign w_scanning  = (r_state == ST_SCAN);
  assign w_begin     = w_scanning ? i_redo : (i_start || i_redo);
  assign w_last_spr  = (r_spr_idx == SPR_W'(NUM_SPRITES - 1));
  assign w_last_pair = w_last_spr && (r_obj_idx == IDX_W'(OBJECT_NUM - 1));
  assign w_publish   = w_scanning && !i_redo && w_last_pair;

  // Accumulator values after folding in the pair evaluated this cycle; the
  // first object to touch a sprite is kept, later hits only add flags.
  always_comb begin
    w_acc_contact_nxt = r_acc_contact;
    w_acc_valid_nxt   = r_acc_valid;
    w_acc_index_nxt   = r_acc_index;
    w_acc_object_nxt  = r_acc_object;
    w_acc_contact_nxt[r_spr_idx*4 +: 4] = r_acc_contact[r_spr_idx*4 +: 4] | w_dir;
    if ((|w_dir) && !r_acc_valid[r_spr_idx]) begin
      w_acc_valid_nxt[r_spr_idx]                  = 1'b1;
      w_acc_index_nxt[r_spr_idx*IDX_W +: IDX_W]   = r_obj_idx;
      w_acc_object_nxt[r_spr_idx*OBJ_W +: OBJ_W]  = w_obj;
    end
  end

  // FSM, pair counters and sprite snapshot; sprites advance fastest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_obj_idx <= '0;
      r_spr_idx <= '0;
      r_snap_x  <= '0;
      r_snap_y  <= '0;
    end else if (w_begin) begin
      r_state   <= ST_SCAN;
      r_obj_idx <= '0;
      r_spr_idx <= '0;
      r_snap_x  <= i_sprite_x;
      r_snap_y  <= i_sprite_y;
    end else if (w_scanning) begin
      if (w_last_pair) begin
        r_state   <= ST_PUBLISH;
        r_obj_idx <= '0;
        r_spr_idx <= '0;
      end else if (w_last_spr) begin
        r_spr_idx <= '0;
        r_obj_idx <= r_obj_idx + IDX_W'(1);
      end else begin
        r_spr_idx <= r_spr_idx + SPR_W'(1);
      end
    end else begin
      r_state <= ST_IDLE;
    end
  end

  // Working accumulators, cleared whenever a scan (re)starts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_contact <= '0;
      r_acc_valid   <= '0;
      r_acc_index   <= '0;
      r_acc_object  <= '0;
    end else if (w_begin) begin
      r_acc_contact <= '0;
      r_acc_valid   <= '0;
      r_acc_index   <= '0;
      r_acc_object  <= '0;
    end else if (w_scanning) begin
      r_acc_contact <= w_acc_contact_nxt;
      r_acc_valid   <= w_acc_valid_nxt;
      r_acc_index   <= w_acc_index_nxt;
      r_acc_object  <= w_acc_object_nxt;
    end
  end

  // Published results, including the final pair, land with the done pulse
  // and then hold until the next completed scan.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done       <= 1'b0;
      r_contact    <= '0;
      r_hit_valid  <= '0;
      r_hit_index  <= '0;
      r_hit_object <= '0;
    end else begin
      r_done <= w_publish;
      if (w_publish) begin
        r_contact    <= w_acc_contact_nxt;
        r_hit_valid  <= w_acc_valid_nxt;
        r_hit_index  <= w_acc_index_nxt;
        r_hit_object <= w_acc_object_nxt;
      end
    end
  end

  assign o_busy       = w_scanning;
  assign o_done       = r_done;
  assign o_contact    = r_contact;
  assign o_hit_valid  = r_hit_valid;
  assign o_hit_index  = r_hit_index;
  assign o_hit_object = r_hit_object;

endmodule

// File: tb/tb_collision_scanner.sv
// Self-checking bench for collision_scanner: a cycle-level reference model
// built from the geometric contact rules, checked against the DUT on every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_collision_scanner;

  localparam int OBJECT_NUM  = 18;
  localparam int NUM_SPRITES = 2;
  localparam int COORD_W     = 11;
  localparam int CW          = 22;
  localparam int CH          = 36;
  localparam int MG          = 1;
  localparam int IDX_W       = 5;
  localparam int OBJ_W       = 4 * COORD_W;
  localparam int SCAN_CYCLES = OBJECT_NUM * NUM_SPRITES;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic start = 1'b0;
  logic redo = 1'b0;
  logic [NUM_SPRITES*COORD_W-1:0] sprX = '0;
  logic [NUM_SPRITES*COORD_W-1:0] sprY = '0;
  logic [OBJECT_NUM*OBJ_W-1:0]    objects = '0;
  logic [OBJECT_NUM-1:0]          objEnable = '0;

  logic                           busy;
  logic                           done;
  logic [NUM_SPRITES*4-1:0]       contact;
  logic [NUM_SPRITES-1:0]         hitValid;
  logic [NUM_SPRITES*IDX_W-1:0]   hitIndex;
  logic [NUM_SPRITES*OBJ_W-1:0]   hitObject;

  int vectors = 0;
  int miscompares = 0;

  collision_scanner #(
    .OBJECT_NUM  (OBJECT_NUM),
    .NUM_SPRITES (NUM_SPRITES),
    .COORD_W     (COORD_W),
    .CHAR_WIDTH  (CW),
    .CHAR_HEIGHT (CH),
    .MARGIN      (MG)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_start      (start),
    .i_redo       (redo),
    .i_sprite_x   (sprX),
    .i_sprite_y   (sprY),
    .i_objects    (objects),
    .i_obj_enable (objEnable),
    .o_busy       (busy),
    .o_done       (done),
    .o_contact    (contact),
    .o_hit_valid  (hitValid),
    .o_hit_index  (hitIndex),
    .o_hit_object (hitObject)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [OBJ_W-1:0] packObj(input int l, input int t, input int r, input int b);
    return {11'(l), 11'(t), 11'(r), 11'(b)};
  endfunction

  // Contact rule in plain integer arithmetic.
  function automatic logic [3:0] refContact(input int l, input int t, input int r, input int b,
                                            input int sx, input int sy);
    int bm, rm;
    logic hov, vov, up, dn, lf, rt;
    if (r <= l || b <= t) return 4'b0000;
    bm  = (b - MG < 0) ? 0 : b - MG;
    rm  = (r - MG < 0) ? 0 : r - MG;
    hov = (sx < r) && (sx + CW > l);
    vov = (sy < b) && (sy + CH > t);
    dn  = hov && (t <= sy + CH) && (sy + CH <= t + MG);
    up  = hov && (bm <= sy) && (sy <= b);
    rt  = vov && (l <= sx + CW) && (sx + CW <= l + MG);
    lf  = vov && (rm <= sx) && (sx <= r);
    return {up, dn, lf, rt};
  endfunction

  // Reference model state.
  int                             mdlRemaining = 0;
  logic                           mdlDone = 1'b0;
  logic [NUM_SPRITES*COORD_W-1:0] mdlSnapX = '0;
  logic [NUM_SPRITES*COORD_W-1:0] mdlSnapY = '0;
  logic [NUM_SPRITES*4-1:0]       mdlContact = '0;
  logic [NUM_SPRITES-1:0]         mdlValid = '0;
  logic [NUM_SPRITES*IDX_W-1:0]   mdlIndex = '0;
  logic [NUM_SPRITES*OBJ_W-1:0]   mdlObject = '0;

  function automatic void modelPublish();
    logic [OBJ_W-1:0] e;
    logic [3:0] d, acc;
    logic found;
    mdlContact = '0; mdlValid = '0; mdlIndex = '0; mdlObject = '0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      acc = 4'b0000;
      found = 1'b0;
      for (int o = 0; o < OBJECT_NUM; o++) begin
        e = objects[o*OBJ_W +: OBJ_W];
        d = 4'b0000;
        if (objEnable[o])
          d = refContact(int'(e[43:33]), int'(e[32:22]), int'(e[21:11]), int'(e[10:0]),
                         int'(mdlSnapX[s*COORD_W +: COORD_W]), int'(mdlSnapY[s*COORD_W +: COORD_W]));
        acc |= d;
        if (d != 4'b0000 && !found) begin
          found = 1'b1;
          mdlIndex[s*IDX_W +: IDX_W] = IDX_W'(o);
          mdlObject[s*OBJ_W +: OBJ_W] = e;
        end
      end
      mdlContact[s*4 +: 4] = acc;
      mdlValid[s] = found;
    end
  endfunction

  // Model: a scan takes SCAN_CYCLES clocks after it is accepted; redo always
  // restarts, start only when no scan is running.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mdlRemaining = 0; mdlDone = 1'b0;
      mdlContact = '0; mdlValid = '0; mdlIndex = '0; mdlObject = '0;
    end else begin
      mdlDone = 1'b0;
      if (redo || (start && mdlRemaining == 0)) begin
        mdlSnapX = sprX; mdlSnapY = sprY;
        mdlRemaining = SCAN_CYCLES;
      end else if (mdlRemaining > 0) begin
        mdlRemaining--;
        if (mdlRemaining == 0) begin
          modelPublish();
          mdlDone = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("busy", busy, mdlRemaining > 0);
    checkOutput("done", done, mdlDone);
    checkOutput("contact", contact, mdlContact);
    checkOutput("hit_valid", hitValid, mdlValid);
    checkOutput("hit_index", hitIndex, mdlIndex);
    checkOutput("hit_object", hitObject, mdlObject);
  end

  task automatic setSprite(input int s, input int x, input int y);
    sprX[s*COORD_W +: COORD_W] = 11'(x);
    sprY[s*COORD_W +: COORD_W] = 11'(y);
  endtask

  task automatic clearTable();
    objects = '0;
    objEnable = '0;
  endtask

  task automatic setObj(input int i, input int l, input int t, input int r, input int b);
    objects[i*OBJ_W +: OBJ_W] = packObj(l, t, r, b);
    objEnable[i] = 1'b1;
  endtask

  // Runs one scan; optionally pulses redo in cycle redoAt with new sprites.
  // lat is the cycle in which done is seen, start being cycle 0.
  task automatic applyStimulus(input int redoAt, input logic [21:0] newX, input logic [21:0] newY,
                               output int lat);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    while (!done && lat < 200) begin
      if (lat == redoAt) begin
        redo = 1'b1; sprX = newX; sprY = newY;
      end else begin
        redo = 1'b0;
      end
      @(negedge clk); lat++;
    end
    redo = 1'b0;
    checkOutput("scan completes", done, 1'b1);
  endtask

  task automatic randomizeScene();
    int sx, sy, l, t, r, b, s, mode;
    clearTable();
    for (int k = 0; k < NUM_SPRITES; k++) setSprite(k, $urandom_range(40, 150), $urandom_range(40, 150));
    for (int i = 0; i < OBJECT_NUM; i++) begin
      s = $urandom_range(0, NUM_SPRITES - 1);
      sx = int'(sprX[s*COORD_W +: COORD_W]);
      sy = int'(sprY[s*COORD_W +: COORD_W]);
      mode = $urandom_range(0, 5);
      l = $urandom_range(0, 150); r = l + $urandom_range(0, 60);
      t = $urandom_range(0, 150); b = t + $urandom_range(0, 60);
      case (mode)
        1: begin t = sy + CH - $urandom_range(0, 2); b = t + $urandom_range(1, 40);
                 l = sx - $urandom_range(0, 30); r = sx + $urandom_range(0, 40); end
        2: begin b = sy + $urandom_range(0, 2); t = b - $urandom_range(1, 30);
                 l = sx - $urandom_range(0, 30); r = sx + $urandom_range(0, 40); end
        3: begin l = sx + CW - $urandom_range(0, 2); r = l + $urandom_range(1, 40);
                 t = sy - $urandom_range(0, 30); b = sy + $urandom_range(0, 40); end
        4: begin r = sx + $urandom_range(0, 2); l = r - $urandom_range(1, 30);
                 t = sy - $urandom_range(0, 30); b = sy + $urandom_range(0, 40); end
        default: ;
      endcase
      objects[i*OBJ_W +: OBJ_W] = packObj(l, t, r, b);
      objEnable[i] = ($urandom_range(0, 5) != 0);
    end
  endtask

  initial begin
    int lat, nDone, cyc;
    logic redoUsed;

    $display("[TB] collision_scanner bench starting");
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset contact", contact, 8'h00);
    checkOutput("reset hit_valid", hitValid, 2'b00);
    rstN = 1'b1;

    // Down contact on a single object, latency pinned.
    clearTable(); setObj(0, 80, 100, 190, 115);
    setSprite(0, 100, 64); setSprite(1, 1500, 1500);
    applyStimulus(0, '0, '0, lat);
    checkOutput("t1 latency", lat, 37);
    checkOutput("t1 contact", contact, 8'b0000_0100);
    checkOutput("t1 hit_valid", hitValid, 2'b01);
    checkOutput("t1 hit_index", hitIndex[4:0], 5'd0);
    checkOutput("t1 hit_object", hitObject[43:0], packObj(80, 100, 190, 115));

    // Sprite 1 lands on object 3, then touches its right edge exactly.
    clearTable(); setObj(3, 0, 300, 200, 340);
    setSprite(0, 1500, 1500); setSprite(1, 58, 264);
    applyStimulus(0, '0, '0, lat);
    checkOutput("t2 down contact", contact, 8'b0100_0000);
    checkOutput("t2 hit_valid", hitValid, 2'b10);
    checkOutput("t2 hit_index", hitIndex[9:5], 5'd3);
    checkOutput("t2 hit_object", hitObject[87:44], packObj(0, 300, 200, 340));
    setSprite(1, 200, 300);
    applyStimulus(0, '0, '0, lat);
    checkOutput("t2 left contact", contact, 8'b0010_0000);
    checkOutput("t2 left hit_index", hitIndex[9:5], 5'd3);

    // Two objects touching: lowest index wins, flags are ORed.
    clearTable(); setObj(2, 80, 100, 190, 115); setObj(3, 122, 50, 300, 90);
    setSprite(0, 100, 64); setSprite(1, 1500, 1500);
    applyStimulus(0, '0, '0, lat);
    checkOutput("t3 contact", contact, 8'b0000_0101);
    checkOutput("t3 hit_index", hitIndex[4:0], 5'd2);
    checkOutput("t3 hit_object", hitObject[43:0], packObj(80, 100, 190, 115));

    // Reset in the middle of a scan clears everything at once.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mid reset busy", busy, 1'b0);
    checkOutput("mid reset contact", contact, 8'h00);
    checkOutput("mid reset hit_valid", hitValid, 2'b00);
    checkOutput("mid reset hit_object", hitObject, '0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    nDone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nDone++;
    end
    checkOutput("no done after reset", nDone, 0);
    applyStimulus(0, '0, '0, lat);
    checkOutput("post reset latency", lat, 37);
    checkOutput("post reset contact", contact, 8'b0000_0101);

    // Everything disabled: no contacts, timing unchanged.
    objEnable = '0;
    applyStimulus(0, '0, '0, lat);
    checkOutput("t4 latency", lat, 37);
    checkOutput("t4 contact", contact, 8'h00);
    checkOutput("t4 hit_valid", hitValid, 2'b00);
    checkOutput("t4 hit_index", hitIndex, 10'd0);

    // Redo at cycle 10 moves sprite 0 onto the object's bottom edge.
    clearTable(); setObj(0, 80, 100, 190, 115);
    setSprite(0, 100, 64); setSprite(1, 1500, 1500);
    applyStimulus(10, {11'd1500, 11'd100}, {11'd1500, 11'd115}, lat);
    checkOutput("t5 latency", lat, 47);
    checkOutput("t5 contact", contact, 8'b0000_1000);

    // Randomized scans with mid-scan sprite changes, ignored starts and redo.
    for (int iter = 0; iter < 40; iter++) begin
      @(negedge clk);
      randomizeScene();
      start = 1'b1;
      cyc = 0;
      redoUsed = 1'b0;
      do begin
        @(negedge clk); cyc++;
        start = 1'b0; redo = 1'b0;
        if (!done) begin
          if ($urandom_range(0, 7) == 0) setSprite($urandom_range(0, 1), $urandom_range(40, 150), $urandom_range(40, 150));
          if ($urandom_range(0, 9) == 0) start = 1'b1;
          if (!redoUsed && $urandom_range(0, 29) == 0) begin
            redo = 1'b1; redoUsed = 1'b1;
            setSprite(0, $urandom_range(40, 150), $urandom_range(40, 150));
          end
        end
      end while (!done && cyc < 200);
      checkOutput("random scan completes", done, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
